// File: rtl/heat_grid_pkg.sv
// Shared definitions for the heat-grid host controller.
// Holds the grid size, the solver mode encodings driven onto ui_in[7:6],
// and the sequencing FSM state type.
package heat_grid_pkg;

  localparam int CELLS = 25;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_WRITE = 2'b01,
    MODE_READ  = 2'b10,
    MODE_CFG   = 2'b11
  } sol_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    CFG_A,
    CFG_B,
    LOAD,
    RUN,
    RD_SET,
    RD_CAP,
    RD_HOLD
  } state_e;

endpackage

// File: rtl/heat_grid_host_if.sv
// Bundle of every non-clock signal of heat_grid_host.
//   control : start, abort, cfg_alpha, cfg_boundary, cfg_sweeps, busy, done
//   load    : ld_valid, ld_ready, ld_data   (initial temperatures, cell 0 first)
//   readback: rb_valid, rb_ready, rb_data, rb_idx, rb_last
//   solver  : sol_mode, sol_addr, sol_wdata, sol_rdata
// master = the host controller, slave = whoever drives it (and models the solver).
interface heat_grid_host_if #(
  parameter int SWEEP_W = 8
);
  logic               start;
  logic               abort;
  logic [2:0]         cfg_alpha;
  logic [3:0]         cfg_boundary;
  logic [SWEEP_W-1:0] cfg_sweeps;
  logic               ld_valid;
  logic               ld_ready;
  logic [3:0]         ld_data;
  logic               rb_valid;
  logic               rb_ready;
  logic [3:0]         rb_data;
  logic [4:0]         rb_idx;
  logic               rb_last;
  logic [1:0]         sol_mode;
  logic [4:0]         sol_addr;
  logic [7:0]         sol_wdata;
  logic [3:0]         sol_rdata;
  logic               busy;
  logic               done;

  modport master (
    input  start, abort, cfg_alpha, cfg_boundary, cfg_sweeps,
    input  ld_valid, ld_data, rb_ready, sol_rdata,
    output ld_ready, rb_valid, rb_data, rb_idx, rb_last,
    output sol_mode, sol_addr, sol_wdata, busy, done
  );

  modport slave (
    output start, abort, cfg_alpha, cfg_boundary, cfg_sweeps,
    output ld_valid, ld_data, rb_ready, sol_rdata,
    input  ld_ready, rb_valid, rb_data, rb_idx, rb_last,
    input  sol_mode, sol_addr, sol_wdata, busy, done
  );
endinterface

// File: rtl/hg_rb_reg.sv
// Ready/valid output register for the readback stream.
// Ports: clk, rst_n; i_clr (drop valid), i_load (capture a beat),
//        i_data/i_idx/i_last (beat payload), i_ready (sink ready);
//        o_valid/o_data/o_idx/o_last (registered stream outputs).
module hg_rb_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [3:0] i_data,
  input  logic [4:0] i_idx,
  input  logic       i_last,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [3:0] o_data,
  output logic [4:0] o_idx,
  output logic       o_last
);
  logic       r_valid;
  logic [3:0] r_data;
  logic [4:0] r_idx;
  logic       r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_idx   <= i_idx;
      r_last  <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_idx   = r_idx;
  assign o_last  = r_last;
endmodule

// File: rtl/heat_grid_host.sv
// Host sequencer for the 5x5 heat-diffusion solver: configures it, streams
// the initial grid in, lets it run sweeps*CELLS cycles, then reads every cell
// back out over a ready/valid stream.
// Ports: clk, rst_n; bus (heat_grid_host_if.master) carrying control,
//        load stream, readback stream and the solver pin bus.
//
// state   | meaning
// IDLE    | solver parked in read mode, waiting for start
// CFG_A   | write alpha to config register 0
// CFG_B   | write boundary temperature to config register 1
// LOAD    | accept one cell per beat, write it on the following cycle
// RUN     | solver free-runs sweeps*CELLS cycles
// RD_SET  | present read address k, let solver output settle
// RD_CAP  | capture sol_rdata into the readback register
// RD_HOLD | wait for the readback handshake
module heat_grid_host #(
  parameter int CELLS   = heat_grid_pkg::CELLS,
  parameter int SWEEP_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  heat_grid_host_if.master bus
);
  import heat_grid_pkg::*;

  localparam int               RUN_W   = SWEEP_W + 5;
  localparam logic [4:0]       LAST_K  = 5'(CELLS - 1);
  localparam logic [4:0]       END_K   = 5'(CELLS);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  state_e             r_state;
  sol_mode_e          r_sol_mode;
  logic [4:0]         r_sol_addr;
  logic [7:0]         r_sol_wdata;
  logic               r_ld_ready;
  logic               r_busy;
  logic               r_done;
  logic [3:0]         r_bound;
  logic [SWEEP_W-1:0] r_sweeps;
  logic [4:0]         r_k;
  logic [RUN_W-1:0]   r_run_cnt;

  logic [RUN_W-1:0]   w_run_len;
  logic               w_rb_load;
  logic               w_rb_valid;
  logic [3:0]         w_rb_data;
  logic [4:0]         w_rb_idx;
  logic               w_rb_last;

  assign w_run_len = RUN_W'(r_sweeps) * RUN_W'(CELLS);
  assign w_rb_load = (r_state == RD_CAP);

  hg_rb_reg u_rb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (bus.abort),
    .i_load  (w_rb_load),
    .i_data  (bus.sol_rdata),
    .i_idx   (r_k),
    .i_last  (r_k == LAST_K),
    .i_ready (bus.rb_ready),
    .o_valid (w_rb_valid),
    .o_data  (w_rb_data),
    .o_idx   (w_rb_idx),
    .o_last  (w_rb_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sol_mode  <= MODE_READ;
      r_sol_addr  <= '0;
      r_sol_wdata <= '0;
      r_ld_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bound     <= '0;
      r_sweeps    <= '0;
      r_k         <= '0;
      r_run_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state     <= IDLE;
        r_sol_mode  <= MODE_READ;
        r_sol_addr  <= '0;
        r_sol_wdata <= '0;
        r_ld_ready  <= 1'b0;
        r_busy      <= 1'b0;
        r_k         <= '0;
        r_run_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.start) begin
              // alpha goes straight into the write-data register, which
              // holds it for the single cycle it is needed
              r_bound     <= bus.cfg_boundary;
              r_sweeps    <= bus.cfg_sweeps;
              r_sol_mode  <= MODE_CFG;
              r_sol_addr  <= 5'd0;
              r_sol_wdata <= {5'b0, bus.cfg_alpha};
              r_busy      <= 1'b1;
              r_k         <= '0;
              r_state     <= CFG_A;
            end
          end
          CFG_A: begin
            r_sol_mode  <= MODE_CFG;
            r_sol_addr  <= 5'd1;
            r_sol_wdata <= {4'b0, r_bound};
            r_state     <= CFG_B;
          end
          CFG_B: begin
            r_sol_mode  <= MODE_READ;
            r_sol_addr  <= '0;
            r_sol_wdata <= '0;
            r_k         <= '0;
            r_ld_ready  <= 1'b1;
            r_state     <= LOAD;
          end
          LOAD: begin
            r_sol_mode <= MODE_READ;
            if (r_k == END_K) begin
              // the last cell's write is on the bus this cycle
              r_k        <= '0;
              r_sol_addr <= '0;
              if (r_sweeps == '0) begin
                r_state <= RD_SET;
              end else begin
                r_sol_mode <= MODE_RUN;
                r_run_cnt  <= w_run_len;
                r_state    <= RUN;
              end
            end else if (bus.ld_valid && r_ld_ready) begin
              r_sol_mode  <= MODE_WRITE;
              r_sol_addr  <= r_k;
              r_sol_wdata <= {4'b0, bus.ld_data};
              r_k         <= r_k + 5'd1;
              if (r_k == LAST_K) r_ld_ready <= 1'b0;
            end
          end
          RUN: begin
            if (r_run_cnt == RUN_ONE) begin
              r_run_cnt  <= '0;
              r_sol_mode <= MODE_READ;
              r_sol_addr <= r_k;
              r_state    <= RD_SET;
            end else begin
              r_sol_mode <= MODE_RUN;
              r_run_cnt  <= r_run_cnt - RUN_ONE;
            end
          end
          RD_SET:  r_state <= RD_CAP;
          RD_CAP:  r_state <= RD_HOLD;
          RD_HOLD: begin
            if (w_rb_valid && bus.rb_ready) begin
              if (w_rb_last) begin
                r_done     <= 1'b1;
                r_busy     <= 1'b0;
                r_k        <= '0;
                r_sol_addr <= '0;
                r_state    <= IDLE;
              end else begin
                r_k        <= r_k + 5'd1;
                r_sol_addr <= r_k + 5'd1;
                r_state    <= RD_SET;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sol_mode  = r_sol_mode;
  assign bus.sol_addr  = r_sol_addr;
  assign bus.sol_wdata = r_sol_wdata;
  assign bus.ld_ready  = r_ld_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rb_valid  = w_rb_valid;
  assign bus.rb_data   = w_rb_data;
  assign bus.rb_idx    = w_rb_idx;
  assign bus.rb_last   = w_rb_last;
endmodule

// File: tb/tb_heat_grid_host.sv
// Self-checking bench for heat_grid_host with a behavioural solver model.
module tb_heat_grid_host;
  localparam int CELLS = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  heat_grid_host_if #(.SWEEP_W(8)) hg ();

  heat_grid_host #(.CELLS(CELLS), .SWEEP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hg.master)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [2:0] alpha;
    logic [3:0] boundary;
    logic [7:0] sweeps;
    int         stall_idx;
    int         exp_run;
    int         exp_stall;
  } job_t;

  wr_t        cfg_q[$];
  wr_t        wr_q[$];
  logic [3:0] rb_q[$];

  // solver model: run mode adds alpha to one cell per cycle, round-robin
  logic [3:0] grid[32];
  logic [2:0] m_alpha = '0;
  int         ptr = 0;

  always @(posedge clk) begin
    case (hg.sol_mode)
      2'b01: grid[hg.sol_addr] <= hg.sol_wdata[3:0];
      2'b11: if (hg.sol_addr == 5'd0) m_alpha <= hg.sol_wdata[2:0];
      2'b00: begin
        grid[ptr] <= grid[ptr] + {1'b0, m_alpha};
        ptr <= (ptr == CELLS - 1) ? 0 : ptr + 1;
      end
      default: ;
    endcase
  end

  assign hg.sol_rdata = grid[hg.sol_addr];

  // bus monitor
  int run_total, cur_streak, max_streak, wr_cnt, cfg_cnt, done_cnt;

  always @(negedge clk) begin
    wr_t e;
    case (hg.sol_mode)
      2'b11: begin
        cfg_cnt++;
        if (cfg_q.size() == 0) check("cfg_unexpected", cfg_q.size(), 1);
        else begin
          e = cfg_q.pop_front();
          check("cfg_addr", int'(hg.sol_addr), int'(e.addr));
          check("cfg_wdata", int'(hg.sol_wdata), int'(e.data));
        end
      end
      2'b01: begin
        wr_cnt++;
        if (wr_q.size() == 0) check("wr_unexpected", wr_q.size(), 1);
        else begin
          e = wr_q.pop_front();
          check("wr_addr", int'(hg.sol_addr), int'(e.addr));
          check("wr_wdata", int'(hg.sol_wdata), int'(e.data));
        end
      end
      2'b00: begin
        run_total++;
        cur_streak++;
        if (cur_streak > max_streak) max_streak = cur_streak;
      end
      default: ;
    endcase
    if (hg.sol_mode != 2'b00) cur_streak = 0;
    if (hg.done) done_cnt++;
  end

  task automatic clear_mon();
    run_total = 0; cur_streak = 0; max_streak = 0;
    wr_cnt = 0; cfg_cnt = 0; done_cnt = 0;
  endtask

  task automatic start_job(input job_t j);
    @(negedge clk);
    hg.cfg_alpha    = j.alpha;
    hg.cfg_boundary = j.boundary;
    hg.cfg_sweeps   = j.sweeps;
    hg.start        = 1'b1;
    cfg_q.push_back('{5'd0, {5'b0, j.alpha}});
    cfg_q.push_back('{5'd1, {4'b0, j.boundary}});
    @(negedge clk);
    hg.start        = 1'b0;
    // scramble inputs: the job must use the values sampled at start
    hg.cfg_alpha    = ~j.alpha;
    hg.cfg_boundary = ~j.boundary;
    hg.cfg_sweeps   = j.sweeps + 8'd1;
  endtask

  task automatic load_grid(input job_t j);
    logic [3:0] v[CELLS];
    int  i = 0;
    int  budget = 0;
    bit  rdy;
    for (int c = 0; c < CELLS; c++) begin
      v[c] = 4'($urandom_range(0, 15));
      rb_q.push_back(4'(int'(v[c]) + int'(j.sweeps) * int'(j.alpha)));
    end
    while (i < CELLS && budget < 400) begin
      @(negedge clk);
      hg.ld_valid = 1'b1;
      hg.ld_data  = v[i];
      rdy = hg.ld_ready;
      if (rdy) wr_q.push_back('{5'(i), {4'b0, v[i]}});
      @(negedge clk);
      hg.ld_valid = 1'b0;
      if (rdy) i++;
      budget++;
    end
    check("load_beats", i, CELLS);
  endtask

  task automatic run_job(input job_t j, input bit inject);
    int beats = 0, stall = 0, lasts = 0, cyc = 0;
    clear_mon();
    start_job(j);
    load_grid(j);
    while (beats < CELLS && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      hg.start = inject && (cyc == 3);
      if (hg.rb_valid) begin
        if (rb_q.size() == 0) check("rb_unexpected", rb_q.size(), 1);
        else begin
          check("rb_data", int'(hg.rb_data), int'(rb_q[0]));
          check("rb_idx", int'(hg.rb_idx), beats);
          check("rb_last", int'(hg.rb_last), int'(beats == CELLS - 1));
          if (int'(hg.rb_idx) == j.stall_idx && stall < 4) begin
            hg.rb_ready = 1'b0;
            stall++;
          end else begin
            hg.rb_ready = 1'b1;
            void'(rb_q.pop_front());
            if (hg.rb_last) lasts++;
            beats++;
          end
        end
      end else begin
        hg.rb_ready = (cyc % 2 == 1);
      end
    end
    hg.start = 1'b0;
    repeat (3) @(negedge clk);
    hg.rb_ready = 1'b0;
    check("rb_beats", beats, CELLS);
    check("rb_last_count", lasts, 1);
    check("rb_stall_cycles", stall, j.exp_stall);
    check("run_cycles", run_total, j.exp_run);
    check("run_streak", max_streak, j.exp_run);
    check("wr_cycles", wr_cnt, CELLS);
    check("cfg_cycles", cfg_cnt, 2);
    check("done_pulses", done_cnt, 1);
    check("idle_mode", int'(hg.sol_mode), 2);
    check("idle_busy", int'(hg.busy), 0);
    check("wr_q_left", wr_q.size(), 0);
    check("cfg_q_left", cfg_q.size(), 0);
  endtask

  job_t jobs[4];

  initial begin
    job_t ja;
    int   rc, b;
    jobs[0] = '{3'd2, 4'd9,  8'd3, 7,  75, 4};
    jobs[1] = '{3'd5, 4'd0,  8'd0, -1, 0,  0};
    jobs[2] = '{3'd7, 4'd15, 8'd1, 24, 25, 4};
    jobs[3] = '{3'd1, 4'd4,  8'd2, 0,  50, 4};

    hg.start = 1'b0; hg.abort = 1'b0;
    hg.cfg_alpha = '0; hg.cfg_boundary = '0; hg.cfg_sweeps = '0;
    hg.ld_valid = 1'b0; hg.ld_data = '0; hg.rb_ready = 1'b0;
    for (int c = 0; c < 32; c++) grid[c] = '0;
    clear_mon();

    // asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_sol_mode", int'(hg.sol_mode), 2);
    check("rst_busy", int'(hg.busy), 0);
    check("rst_rb_valid", int'(hg.rb_valid), 0);
    check("rst_ld_ready", int'(hg.ld_ready), 0);
    check("rst_done", int'(hg.done), 0);
    check("rst_sol_wdata", int'(hg.sol_wdata), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 4; n++) run_job(jobs[n], n == 2);

    // abort during the 10th RUN cycle
    ja = '{3'd3, 4'd2, 8'd3, -1, 75, 0};
    clear_mon();
    start_job(ja);
    load_grid(ja);
    rc = 0; b = 0;
    while (rc < 10 && b < 500) begin
      @(posedge clk); #1;
      if (hg.sol_mode == 2'b00) rc++;
      b++;
    end
    check("abort_reach_run", rc, 10);
    hg.abort = 1'b1;
    @(posedge clk); #1;
    check("abort_sol_mode", int'(hg.sol_mode), 2);
    check("abort_busy", int'(hg.busy), 0);
    check("abort_ld_ready", int'(hg.ld_ready), 0);
    check("abort_rb_valid", int'(hg.rb_valid), 0);
    hg.abort = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_run_cycles", run_total, 10);
    check("abort_wr_q", wr_q.size(), 0);
    rb_q.delete();
    cfg_q.delete();

    run_job('{3'd6, 4'd11, 8'd2, 7, 50, 4}, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
